// File: rtl/param_fir_filter.sv
`default_nettype none
// ============================================================================
//  Module   : param_fir_filter
//  Brief    : NTAPS-tap direct-form FIR with a writable coefficient bank,
//             valid-qualified streaming and a 3-stage multiply/sum/scale pipe.
//             Define FIR_SAT_EN to clamp the scaled result into OUT_W.
//  Revision : 1.0 - initial release
// ============================================================================
module param_fir_filter #(
    parameter int NTAPS  = 6,
    parameter int DATA_W = 16,
    parameter int COEF_W = 14,
    parameter int OUT_W  = 26,
    parameter int SHIFT  = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic signed [DATA_W-1:0]   din,
    input  logic                       flush,
    input  logic                       coef_we,
    input  logic [$clog2(NTAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data,
    output logic                       out_valid,
    output logic signed [OUT_W-1:0]    dout,
    output logic                       ovf
);

    localparam int ACC_W    = DATA_W + COEF_W + $clog2(NTAPS);
    localparam int C_PROD_W = DATA_W + COEF_W;
    localparam int C_XW     = (ACC_W > OUT_W) ? ACC_W : OUT_W;

    logic signed [DATA_W-1:0]   r_taps     [NTAPS];
    logic signed [DATA_W-1:0]   w_taps_nxt [NTAPS];
    logic signed [COEF_W-1:0]   r_coef     [NTAPS];
    logic signed [C_PROD_W-1:0] w_prod     [NTAPS];
    logic signed [C_PROD_W-1:0] r_prod     [NTAPS];
    logic signed [ACC_W-1:0]    w_sum;
    logic signed [ACC_W-1:0]    r_sum;
    logic signed [ACC_W-1:0]    w_shifted;
    logic signed [C_XW-1:0]     w_wide;
    logic signed [OUT_W-1:0]    w_dout;
    logic                       w_ovf;
    logic                       r_v1;
    logic                       r_v2;

    // Products are formed from the post-shift tap vector so a sample is
    // multiplied on the same edge it is accepted, against the pre-write coefs.
    always_comb begin
        for (int i = 0; i < NTAPS; i++) begin
            w_taps_nxt[i] = r_taps[i];
        end
        if (in_valid) begin
            w_taps_nxt[0] = din;
            for (int i = 1; i < NTAPS; i++) begin
                w_taps_nxt[i] = r_taps[i-1];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NTAPS; i++) begin
            w_prod[i] = $signed({{COEF_W{w_taps_nxt[i][DATA_W-1]}}, w_taps_nxt[i]})
                      * $signed({{DATA_W{r_coef[i][COEF_W-1]}}, r_coef[i]});
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_taps[i] <= '0;
            end
        end else if (in_valid) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_taps[i] <= w_taps_nxt[i];
            end
        end
    end

    // Out-of-range addresses match no entry and are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_coef[i] <= '0;
            end
        end else if (coef_we) begin
            for (int i = 0; i < NTAPS; i++) begin
                if (32'(coef_addr) == i) begin
                    r_coef[i] <= coef_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_prod[i] <= '0;
            end
            r_v1 <= 1'b0;
        end else begin
            for (int i = 0; i < NTAPS; i++) begin
                r_prod[i] <= w_prod[i];
            end
            r_v1 <= in_valid & ~flush;
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NTAPS; i++) begin
            w_sum = w_sum + {{(ACC_W-C_PROD_W){r_prod[i][C_PROD_W-1]}}, r_prod[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum <= '0;
            r_v2  <= 1'b0;
        end else begin
            r_sum <= w_sum;
            r_v2  <= r_v1 & ~flush;
        end
    end

    assign w_shifted = r_sum >>> SHIFT;
    assign w_wide    = C_XW'(w_shifted);

`ifdef FIR_SAT_EN
    localparam logic signed [C_XW-1:0] C_MAX = {1'b0, {(C_XW-1){1'b1}}} >> (C_XW - OUT_W);
    localparam logic signed [C_XW-1:0] C_MIN = ~C_MAX;

    logic signed [C_XW-1:0] w_clip;

    always_comb begin
        w_clip = w_wide;
        w_ovf  = 1'b0;
        if (w_wide > C_MAX) begin
            w_clip = C_MAX;
            w_ovf  = 1'b1;
        end else if (w_wide < C_MIN) begin
            w_clip = C_MIN;
            w_ovf  = 1'b1;
        end
    end

    assign w_dout = OUT_W'(w_clip);
`else
    assign w_dout = OUT_W'(w_wide);
    assign w_ovf  = 1'b0;
`endif

    // dout/ovf only move on a valid result; flush drops the pending one.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            dout      <= '0;
            ovf       <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= r_v2;
            if (r_v2) begin
                dout <= w_dout;
                ovf  <= w_ovf;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_param_fir_filter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_param_fir_filter
//  Brief    : Self-checking bench for param_fir_filter against a dot-product
//             reference model, with directed literal cases and random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_param_fir_filter;

    localparam int NTAPS  = 6;
    localparam int DATA_W = 16;
    localparam int COEF_W = 14;
    localparam int OUT_W  = 26;
    localparam int SHIFT  = 0;
    localparam int AW     = $clog2(NTAPS);

    logic                     clk       = 1'b0;
    logic                     reset     = 1'b1;
    logic                     in_valid  = 1'b0;
    logic signed [DATA_W-1:0] din       = '0;
    logic                     flush     = 1'b0;
    logic                     coef_we   = 1'b0;
    logic [AW-1:0]            coef_addr = '0;
    logic signed [COEF_W-1:0] coef_data = '0;
    logic                     out_valid;
    logic signed [OUT_W-1:0]  dout;
    logic                     ovf;

    always #5 clk = ~clk;

    param_fir_filter #(
        .NTAPS (NTAPS),
        .DATA_W(DATA_W),
        .COEF_W(COEF_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .din      (din),
        .flush    (flush),
        .coef_we  (coef_we),
        .coef_addr(coef_addr),
        .coef_data(coef_data),
        .out_valid(out_valid),
        .dout     (dout),
        .ovf      (ovf)
    );

    typedef struct {
        int     due;
        longint val;
        bit     o;
    } exp_t;

    exp_t   q[$];
    longint h[NTAPS];
    longint c[NTAPS];
    longint last_val = 0;
    bit     last_ovf = 1'b0;
    int     e        = 0;
    bit     chk_en   = 1'b0;
    int     n_cmp    = 0;
    int     n_bad    = 0;
    longint obs[$];
    bit     obs_ovf[$];

    // Scale the exact sum and narrow it the way the output format demands.
    function automatic void model_result(input longint s, output longint v, output bit o);
        longint r;
        longint lim;
        r   = s >>> SHIFT;
        lim = longint'(1) <<< (OUT_W - 1);
        o   = 1'b0;
`ifdef FIR_SAT_EN
        v = r;
        if (r > lim - 1) begin
            v = lim - 1;
            o = 1'b1;
        end else if (r < -lim) begin
            v = -lim;
            o = 1'b1;
        end
`else
        v = r & ((lim <<< 1) - 1);
        if (v >= lim) v = v - (lim <<< 1);
`endif
    endfunction

    // Reference model on the rising edge, output comparison on the falling edge.
    initial begin : model_and_compare
        longint s;
        longint v;
        bit     o;
        bit     ev;
        forever begin
            @(posedge clk);
            e++;
            if (reset) begin
                q.delete();
                for (int i = 0; i < NTAPS; i++) begin
                    h[i] = 0;
                    c[i] = 0;
                end
                last_val = 0;
                last_ovf = 1'b0;
            end else begin
                if (flush) begin
                    q.delete();
                    for (int i = 0; i < NTAPS; i++) h[i] = 0;
                end else if (in_valid) begin
                    for (int i = NTAPS - 1; i > 0; i--) h[i] = h[i-1];
                    h[0] = longint'(din);
                    s = 0;
                    for (int i = 0; i < NTAPS; i++) s += h[i] * c[i];
                    model_result(s, v, o);
                    q.push_back('{due: e + 2, val: v, o: o});
                end
                if (coef_we && int'(coef_addr) < NTAPS) c[coef_addr] = longint'(coef_data);
            end

            @(negedge clk);
            if (chk_en) begin
                ev = (q.size() > 0) && (q[0].due == e);
                if (ev) begin
                    last_val = q[0].val;
                    last_ovf = q[0].o;
                    void'(q.pop_front());
                end
                n_cmp++;
                if (out_valid !== ev) begin
                    n_bad++;
                    $display("FAIL out_valid @edge %0d: got %b expected %b", e, out_valid, ev);
                end
                n_cmp++;
                if (longint'(dout) !== last_val || ovf !== last_ovf) begin
                    n_bad++;
                    $display("FAIL dout/ovf @edge %0d: got %0d/%b expected %0d/%b",
                             e, longint'(dout), ovf, last_val, last_ovf);
                end
                if (out_valid === 1'b1) begin
                    obs.push_back(longint'(dout));
                    obs_ovf.push_back(ovf);
                end
            end
        end
    end

    task automatic drive(input bit rs, input bit v, input logic signed [DATA_W-1:0] d,
                         input bit fl, input bit we, input logic [AW-1:0] a,
                         input logic signed [COEF_W-1:0] cd);
        reset     = rs;
        in_valid  = v;
        din       = d;
        flush     = fl;
        coef_we   = we;
        coef_addr = a;
        coef_data = cd;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic sample(input logic signed [DATA_W-1:0] d);
        drive(1'b0, 1'b1, d, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_flush();
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, '0);
    endtask

    task automatic load_coefs(input bit ramp, input logic signed [COEF_W-1:0] val);
        for (int i = 0; i < NTAPS; i++) begin
            drive(1'b0, 1'b0, '0, 1'b0, 1'b1, AW'(i), ramp ? COEF_W'(i + 1) : val);
        end
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint obs_at(input int k);
        return (k < obs.size()) ? obs[k] : -64'sd999999999;
    endfunction

    initial begin : stimulus
        longint t1_exp[7];
        logic signed [DATA_W-1:0] d;
        logic [AW-1:0]            a;
        logic signed [COEF_W-1:0] cd;
        bit rs, v, fl, we;

        t1_exp = '{1, 2, 3, 4, 5, 6, 0};
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        idle(1);
        chk("reset_dout", longint'(dout), 0);

        // T1 impulse
        load_coefs(1'b1, '0);
        idle(2);
        obs.delete();
        sample(1);
        repeat (6) sample(0);
        idle(6);
        chk("t1_count", obs.size(), 7);
        for (int k = 0; k < 7; k++) chk($sformatf("t1_out%0d", k), obs_at(k), t1_exp[k]);

        // T2 gapped impulse
        obs.delete();
        sample(1);
        repeat (5) begin
            idle(1);
            sample(0);
        end
        idle(6);
        chk("t2_count", obs.size(), 6);
        for (int k = 0; k < 6; k++) chk($sformatf("t2_out%0d", k), obs_at(k), k + 1);

        // T3 extreme accumulation
        load_coefs(1'b0, 14'sd8191);
        obs.delete();
        repeat (6) sample(16'sd32767);
        idle(6);
`ifdef FIR_SAT_EN
        chk("t3_pos_sat", obs_at(5), 33554431);
        chk("t3_pos_ovf", (obs_ovf.size() > 5) ? longint'(obs_ovf[5]) : -1, 1);
        load_coefs(1'b0, -14'sd8192);
        obs.delete();
        repeat (6) sample(16'sd32767);
        idle(6);
        chk("t3_neg_sat", obs_at(5), -33554432);
`else
        chk("t3_wrap", obs_at(5), -245754);
        chk("t3_wrap_ovf", (obs_ovf.size() > 5) ? longint'(obs_ovf[5]) : -1, 0);
`endif

        // T4 coefficient write racing a sample
        load_coefs(1'b1, '0);
        do_flush();
        obs.delete();
        drive(1'b0, 1'b1, 16'sd3, 1'b0, 1'b1, '0, 14'sd10);
        sample(3);
        idle(6);
        chk("t4_old_coef", obs_at(0), 3);
        chk("t4_new_coef", obs_at(1), 36);

        // T5 flush then reset
        load_coefs(1'b1, '0);
        do_flush();
        obs.delete();
        sample(1);
        do_flush();
        idle(6);
        chk("t5_flushed_none", obs.size(), 0);
        sample(5);
        idle(6);
        chk("t5_after_flush", obs_at(0), 5);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        obs.delete();
        sample(5);
        idle(6);
        chk("t5_after_reset", obs_at(0), 0);

        // Random traffic including flush, reset and out-of-range writes
        load_coefs(1'b1, '0);
        for (int k = 0; k < 3000; k++) begin
            rs = ($urandom_range(0, 399) == 0);
            v  = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 39) == 0);
            we = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 7))
                0:       d = 16'sh7fff;
                1:       d = 16'sh8000;
                default: d = DATA_W'($urandom);
            endcase
            a  = AW'($urandom_range(0, 7));
            cd = COEF_W'($urandom);
            drive(rs, v, d, fl, we, a, cd);
        end
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
